// File: rtl/pipe_ctrl_unit.sv
// Pipeline sequencer: warm-up, run, halt with drain, resume with an IF/ID flush pulse.
// Optional single-step support is compiled in with CTRL_SINGLE_STEP_EN.
//
// state  | meaning
// IDLE   | just out of reset, PC held at its start value
// WARMUP | counting down the warm-up period
// RUN    | fetching; PC and register writes gated by stall_req/sw_flag
// DRAIN  | fetch stopped, in-flight instructions retiring
// HALTED | core stopped, waiting for resume (or step)
// STEP   | single fetch, then drain back to HALTED
module pipe_ctrl_unit #(
  parameter int WARMUP_CYCLES = 2,
  parameter int N_STAGES      = 5,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_flag,
  input  logic       stall_req,
  input  logic       halt_req,
  input  logic       resume,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       start_pc,
  output logic       pc_en,
  output logic       regwrite,
  output logic       flush,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4,
    STEP   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] WARM_LD  = CNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(N_STAGES - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (WARMUP_CYCLES == 0) begin
          state_d = RUN;
        end else begin
          state_d = WARMUP;
          cnt_d   = WARM_LD;
        end
      end
      WARMUP: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RUN: begin
        if (halt_req) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = HALTED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HALTED: begin
        if (resume) begin
          state_d = RUN;
          flush_d = 1'b1;
        end
`ifdef CTRL_SINGLE_STEP_EN
        else if (step) begin
          state_d = STEP;
        end
`endif
      end
`ifdef CTRL_SINGLE_STEP_EN
      STEP: begin
        state_d = DRAIN;
        cnt_d   = DRAIN_LD;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Illegal encodings (including STEP when single-step is not built) drive all outputs low.
  always_comb begin
    start_pc = 1'b0;
    pc_en    = 1'b0;
    regwrite = 1'b0;
    case (state_q)
      RUN: begin
        start_pc = 1'b1;
        pc_en    = ~stall_req;
        regwrite = ~sw_flag;
      end
      DRAIN: begin
        start_pc = 1'b1;
        regwrite = ~sw_flag;
      end
      HALTED: start_pc = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
      STEP: begin
        start_pc = 1'b1;
        pc_en    = ~stall_req;
        regwrite = ~sw_flag;
      end
`endif
      default: ;
    endcase
  end

  assign flush   = flush_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: fixed vector table, hand sequences for reset/step corners,
// and randomized traffic checked against a phase-length reference model.
module tb_pipe_ctrl_unit;
  localparam int W = 2;
  localparam int N = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw_flag = 1'b0, stall_req = 1'b0, halt_req = 1'b0, resume = 1'b0, step = 1'b0;
  logic a_start, a_pc, a_rw, a_fl;
  logic [2:0] a_state;
  logic b_start, b_pc, b_rw, b_fl;
  logic [2:0] b_state;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.WARMUP_CYCLES(W), .N_STAGES(N), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset), .sw_flag(sw_flag), .stall_req(stall_req),
    .halt_req(halt_req), .resume(resume),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .start_pc(a_start), .pc_en(a_pc), .regwrite(a_rw), .flush(a_fl), .state_o(a_state)
  );

  pipe_ctrl_unit #(.WARMUP_CYCLES(0), .N_STAGES(N), .CNT_W(4)) u_dut_nowarm (
    .clk(clk), .reset(reset), .sw_flag(sw_flag), .stall_req(stall_req),
    .halt_req(halt_req), .resume(resume),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .start_pc(b_start), .pc_en(b_pc), .regwrite(b_rw), .flush(b_fl), .state_o(b_state)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check5(input string tag, input logic [2:0] st, input logic sp, input logic pc,
                        input logic rw, input logic fl);
    chk({tag, ".state"}, a_state, st);
    chk({tag, ".start_pc"}, {2'b0, a_start}, {2'b0, sp});
    chk({tag, ".pc_en"}, {2'b0, a_pc}, {2'b0, pc});
    chk({tag, ".regwrite"}, {2'b0, a_rw}, {2'b0, rw});
    chk({tag, ".flush"}, {2'b0, a_fl}, {2'b0, fl});
  endtask

  // Reference model: tracks the phase and how many cycles of it remain.
  int   m_st, m_left;
  logic m_flush;

  function automatic void m_reset();
    m_st = 0; m_left = 0; m_flush = 1'b0;
  endfunction

  task automatic m_check(input string tag);
    logic sp, pc, rw;
    sp = (m_st >= 2 && m_st <= 5);
    pc = (m_st == 2 || m_st == 5) && !stall_req;
    rw = (m_st == 2 || m_st == 3 || m_st == 5) && !sw_flag;
    check5(tag, 3'(m_st), sp, pc, rw, m_flush);
  endtask

  function automatic void m_advance();
    logic nf;
    nf = (m_st == 4) && resume;
    case (m_st)
      0: if (W == 0) m_st = 2; else begin m_st = 1; m_left = W; end
      1: begin m_left--; if (m_left == 0) m_st = 2; end
      2: if (halt_req) begin m_st = 3; m_left = N - 1; end
      3: begin m_left--; if (m_left == 0) m_st = 4; end
      4: begin
        if (resume) m_st = 2;
`ifdef CTRL_SINGLE_STEP_EN
        else if (step) m_st = 5;
`endif
      end
      5: begin m_st = 3; m_left = N - 1; end
      default: m_st = 0;
    endcase
    m_flush = nf;
  endfunction

  task automatic drive(input logic sw, input logic st, input logic h, input logic r, input logic s);
    sw_flag = sw; stall_req = st; halt_req = h; resume = r; step = s;
  endtask

  task automatic cyc(input logic sw, input logic st, input logic h, input logic r, input logic s,
                     input string tag);
    @(negedge clk);
    drive(sw, st, h, r, s);
    #1;
    m_check(tag);
    m_advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1;
    m_reset();
    m_check("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_check("cycle0");
    m_advance();
  endtask

  typedef struct {
    logic sw, stall, halt, res;
    logic [2:0] st;
    logic sp, pc, rw, fl;
  } vec_t;

  vec_t tbl[18];

  initial begin
    //            sw stall halt res  st   sp pc rw fl
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0};

    // Table: reset release through warm-up, gating, halt/drain, resume with flush.
    @(negedge clk);
    #1;
    check5("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) reset = 1'b1;
      drive(tbl[i].sw, tbl[i].stall, tbl[i].halt, tbl[i].res, 1'b0);
      #1;
      check5($sformatf("tbl%0d", i), tbl[i].st, tbl[i].sp, tbl[i].pc, tbl[i].rw, tbl[i].fl);
    end

    // Asynchronous reset in the second DRAIN cycle, then warm-up repeats.
    do_reset();
    cyc(0, 0, 0, 0, 0, "rd_w1");
    cyc(0, 0, 0, 0, 0, "rd_w2");
    cyc(0, 0, 1, 0, 0, "rd_run");
    cyc(0, 0, 0, 0, 0, "rd_dr3");
    cyc(0, 0, 0, 0, 0, "rd_dr2");
    #2;
    reset = 1'b0;
    #1;
    check5("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_check("rr_c0");
    chk("nowarm_c0.state", b_state, 3'd0);
    m_advance();
    cyc(0, 0, 0, 0, 0, "rr_c1");
    chk("rr_c1.explicit_state", a_state, 3'd1);
    chk("nowarm_c1.state", b_state, 3'd2);
    cyc(0, 0, 0, 0, 0, "rr_c2");
    chk("rr_c2.explicit_state", a_state, 3'd1);
    cyc(0, 0, 0, 0, 0, "rr_c3");
    chk("rr_c3.explicit_state", a_state, 3'd2);

`ifdef CTRL_SINGLE_STEP_EN
    // resume beats step; a lone step gives one fetch cycle then a full drain.
    cyc(0, 0, 1, 0, 0, "st_run");
    for (int i = 0; i < N - 1; i++) cyc(0, 0, 0, 0, 0, "st_dr");
    cyc(0, 0, 0, 1, 1, "st_both");
    chk("st_both.halted", a_state, 3'd4);
    cyc(0, 0, 0, 0, 0, "st_res");
    chk("step_resume_prio.state", a_state, 3'd2);
    chk("step_resume_prio.flush", {2'b0, a_fl}, 3'd1);
    cyc(0, 0, 1, 0, 0, "st_run2");
    for (int i = 0; i < N - 1; i++) cyc(0, 0, 0, 0, 0, "st_dr2");
    cyc(0, 0, 0, 0, 1, "st_step");
    cyc(0, 0, 0, 0, 0, "st_in_step");
    chk("step.state", a_state, 3'd5);
    chk("step.pc_en", {2'b0, a_pc}, 3'd1);
    for (int i = 0; i < N - 1; i++) begin
      cyc(0, 0, 0, 0, 0, "st_dr3");
      chk($sformatf("step_drain%0d.state", i), a_state, 3'd3);
    end
    cyc(0, 0, 0, 0, 0, "st_halt");
    chk("step_end.state", a_state, 3'd4);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
